// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: fetch FSM encoding and instruction size.
package cpu_pkg;

   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IFETCH_IDLE = 2'd0,
      IFETCH_WAIT = 2'd1,
      IFETCH_DROP = 2'd2
   } ifetch_state_e;

endpackage

// File: rtl/cpu_ifetch_fifo.sv
// Synchronous instruction buffer of {pc, data} entries with flush; DEPTH must be a power of 2.
module cpu_ifetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign wr_en = push && !flush && (!full || pop);
   assign rd_en = pop && !flush && !empty;
   assign rdata = mem[rd_ptr];

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (rd_en) rd_ptr <= rd_ptr + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; validity is tracked by count, so clearing the array buys nothing.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/cpu_instr_fetch.sv
// Instruction fetch unit: owns fetch_pc, issues single-outstanding reads, buffers {pc,data}.
// Define IFETCH_MISALIGN_CHK_EN to flag misaligned redirects and stall fetch until corrected.
module cpu_instr_fetch
   import cpu_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  imem_req,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic                  imem_gnt,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  instr_valid,
   output logic [DATA_WIDTH-1:0] instr_data,
   output logic [ADDR_WIDTH-1:0] instr_pc,
   input  logic                  instr_ready,
   output logic                  misalign_err
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int UW = CW + 1;
   localparam int EW = ADDR_WIDTH + DATA_WIDTH;

   ifetch_state_e         state;
   ifetch_state_e         state_nxt;
   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] req_pc;
   logic [CW-1:0]         count;
   logic                  full;
   logic                  empty;
   logic [EW-1:0]         head;
   logic                  misalign;
   logic                  accept;
   logic                  resp_done;
   logic                  push;
   logic                  pop;
   logic [UW-1:0]         used;

   // A response returning this cycle frees the outstanding slot, and a pop frees a buffer
   // slot, so a new request can overlap both and sustain one fetch per cycle.
   assign pop       = instr_valid && instr_ready && !redirect;
   assign resp_done = (state != IFETCH_IDLE) && imem_rvalid;
   assign push      = (state == IFETCH_WAIT) && imem_rvalid && !redirect;
   assign used      = UW'(count) + UW'(push) - UW'(pop);
   assign imem_req  = rst_n && !redirect && !misalign
                      && ((state == IFETCH_IDLE) || resp_done)
                      && (used < UW'(FIFO_DEPTH));
   assign accept    = imem_req && imem_gnt;
   assign imem_addr = fetch_pc;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IFETCH_IDLE: if (accept) state_nxt = IFETCH_WAIT;
         IFETCH_WAIT: begin
            if (imem_rvalid)   state_nxt = accept ? IFETCH_WAIT : IFETCH_IDLE;
            else if (redirect) state_nxt = IFETCH_DROP;
         end
         IFETCH_DROP: if (imem_rvalid) state_nxt = accept ? IFETCH_WAIT : IFETCH_IDLE;
         default:     state_nxt = IFETCH_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IFETCH_IDLE;
         fetch_pc <= RESET_ADDR;
         req_pc   <= RESET_ADDR;
      end else begin
         state <= state_nxt;
         if (redirect)    fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
         else if (accept) fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
         if (accept)      req_pc   <= fetch_pc;
      end
   end

`ifdef IFETCH_MISALIGN_CHK_EN
   logic misalign_q;

   always_ff @(posedge clk) begin
      if (!rst_n)        misalign_q <= 1'b0;
      else if (redirect) misalign_q <= |redirect_pc[1:0];
   end

   assign misalign     = misalign_q;
   assign misalign_err = misalign_q;
`else
   logic unused_pc_low;

   assign unused_pc_low = ^redirect_pc[1:0];
   assign misalign      = 1'b0;
   assign misalign_err  = 1'b0;
`endif

   cpu_ifetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect),
      .push  (push),
      .wdata ({req_pc, imem_rdata}),
      .pop   (pop),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   assign instr_valid = !empty;
   assign instr_pc    = head[EW-1:DATA_WIDTH];
   assign instr_data  = head[DATA_WIDTH-1:0];

   // Request gating must keep the buffer from ever being written while full.
   no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: tb/tb_cpu_instr_fetch.sv
// Randomized bench for cpu_instr_fetch against a queue-based reference of the fetch rules.
module tb_cpu_instr_fetch;

   localparam int          AW       = 32;
   localparam int          DW       = 32;
   localparam int          DEPTH    = 2;
   localparam logic [31:0] RST_ADDR = 32'h0;
   localparam int          N_CYC    = 6000;

   logic          clk;
   logic          rst_n;
   logic          redirect;
   logic [AW-1:0] redirect_pc;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_gnt;
   logic          imem_rvalid;
   logic [DW-1:0] imem_rdata;
   logic          instr_valid;
   logic [DW-1:0] instr_data;
   logic [AW-1:0] instr_pc;
   logic          instr_ready;
   logic          misalign_err;

   cpu_instr_fetch #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RESET_ADDR (RST_ADDR),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_data   (instr_data),
      .instr_pc     (instr_pc),
      .instr_ready  (instr_ready),
      .misalign_err (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Reference state: buffered instructions in order, one tracked memory transaction.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } ent_t;

   ent_t        q[$];
   bit          busy;
   bit          keep;
   logic [31:0] busy_pc;
   logic [31:0] m_pc;
   bit          mis;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   function automatic logic [31:0] pick_pc();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         2:       return (32'h100 * 32'($urandom_range(1, 3))) | 32'($urandom_range(0, 3));
         default: return 32'($urandom_range(0, 63));
      endcase
   endfunction

   initial begin
      int  p_gnt, p_rv, p_rdy, p_rd;
      int  occ;
      bit  after_rst;
      bit  e_valid, e_pop, e_resp, e_push, e_req, e_acc;

      rst_n       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      instr_ready = 1'b0;
      repeat (2) @(posedge clk);

      q.delete();
      busy      = 0;
      keep      = 0;
      busy_pc   = '0;
      m_pc      = RST_ADDR;
      mis       = 0;
      after_rst = 1;

      for (int cyc = 0; cyc < N_CYC; cyc++) begin
         @(negedge clk);
         case ((cyc / 250) % 4)
            0:       begin p_gnt = 100; p_rv = 100; p_rdy = 100; p_rd = 1;  end
            1:       begin p_gnt = 90;  p_rv = 80;  p_rdy = 10;  p_rd = 3;  end
            2:       begin p_gnt = 30;  p_rv = 40;  p_rdy = 60;  p_rd = 10; end
            default: begin p_gnt = 70;  p_rv = 50;  p_rdy = 50;  p_rd = 30; end
         endcase

         rst_n       = ((cyc % 1000) < 997);
         redirect    = ($urandom_range(0, 99) < p_rd);
         redirect_pc = pick_pc();
         imem_gnt    = ($urandom_range(0, 99) < p_gnt);
         if (busy) begin
            imem_rvalid = ($urandom_range(0, 99) < p_rv);
            imem_rdata  = mem_word(busy_pc);
         end else begin
            // Stray responses, including the cycle right after reset, must be ignored.
            imem_rvalid = after_rst || ($urandom_range(0, 99) < 5);
            imem_rdata  = $urandom;
         end
         instr_ready = ($urandom_range(0, 99) < p_rdy);
         #1;

         e_valid = (q.size() != 0);
         e_pop   = e_valid && instr_ready && !redirect;
         e_resp  = busy && imem_rvalid;
         e_push  = e_resp && keep && !redirect;
         occ     = q.size() - (e_pop ? 1 : 0) + (e_push ? 1 : 0);
         e_req   = rst_n && !redirect && !mis && !(busy && !e_resp) && (occ < DEPTH);
         e_acc   = e_req && imem_gnt;

         check("imem_req", 64'(imem_req), 64'(e_req));
         if (e_req) check("imem_addr", 64'(imem_addr), 64'(m_pc));
         check("instr_valid", 64'(instr_valid), 64'(e_valid));
         if (e_valid) begin
            check("instr_pc", 64'(instr_pc), 64'(q[0].pc));
            check("instr_data", 64'(instr_data), 64'(q[0].data));
         end
         check("misalign_err", 64'(misalign_err), 64'(mis));

         @(posedge clk);
         after_rst = !rst_n;
         if (!rst_n) begin
            q.delete();
            busy = 0;
            keep = 0;
            m_pc = RST_ADDR;
            mis  = 0;
         end else begin
            if (e_pop) void'(q.pop_front());
            if (e_resp) begin
               if (e_push) q.push_back('{pc: busy_pc, data: imem_rdata});
               busy = 0;
            end
            if (redirect) begin
               q.delete();
               m_pc = {redirect_pc[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_CHK_EN
               mis = (redirect_pc[1:0] != 2'b00);
`endif
               if (busy) keep = 0;
            end
            if (e_acc) begin
               busy    = 1;
               keep    = 1;
               busy_pc = m_pc;
               m_pc    = m_pc + 32'd4;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
